// File: rtl/ysyx_23060124_pipe_stage_buf.sv
// ysyx_23060124_pipe_stage_buf: valid/ready pipeline stage register with optional skid entry, flush and hold
module ysyx_23060124_pipe_stage_buf #(
    parameter int DATA_W      = 32,
    parameter int SKID        = 0,
    parameter int ZERO_BUBBLE = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_flush,
    input  logic              i_hold,
    input  logic              i_pre_valid,
    output logic              o_pre_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_post_valid,
    input  logic              i_post_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_count
);
    logic              main_v, skid_v, acc, pop, main_load, skid_load, move, main_v_n, skid_v_n;
    logic [DATA_W-1:0] main_d, skid_d, main_d_n;
    always_comb begin
        o_pre_ready = !i_flush && !i_hold && ((SKID != 0) ? !skid_v : (!main_v || i_post_ready));
        acc         = i_pre_valid && o_pre_ready;
        pop         = main_v && i_post_ready;
        main_load   = acc && (!main_v || pop);
        skid_load   = (SKID != 0) && acc && main_v && !pop;
        move        = (SKID != 0) && skid_v && pop && !i_flush;
        main_v_n    = !i_flush && ((main_v && !pop) || main_load || move);
        skid_v_n    = !i_flush && ((skid_v && !pop) || skid_load);
        // an emptied main register is zeroed so downstream decodes a NOP
        main_d_n    = ((ZERO_BUBBLE != 0) && !main_v_n) ? '0 : main_load ? i_data : move ? skid_d : main_d;
        o_post_valid = main_v;
        o_data       = ((ZERO_BUBBLE != 0) && !main_v) ? '0 : main_d;
        o_count      = {1'b0, main_v} + {1'b0, skid_v};
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_d <= '0;
            skid_d <= '0;
        end else begin
            main_v <= main_v_n;
            skid_v <= skid_v_n;
            main_d <= main_d_n;
            skid_d <= skid_load ? i_data : skid_d;
        end
    end
endmodule
